// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC path.
//   CRC_WIDTH    : word width of the CRC block and of this feeder.
//   state_e      : serializer FSM states.
//   fifo_entry_t : one buffered input word with its frame-end flag.
package crc_pkg;

    localparam int CRC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_CRC = 2'd2
    } state_e;

    typedef struct packed {
        logic                 last;
        logic [CRC_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
//   clk_i, rst_i      : clock, reset (flushes contents).
//   push_i, wdata_i   : write request and data; ignored when full.
//   pop_i, rdata_o    : read request and head-of-queue data (show-ahead);
//                       ignored when empty, so a same-edge push never feeds a pop.
//   full_o, empty_o   : occupancy flags.
//   count_o           : number of stored entries.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/crc_serializer.sv
// Feeder for the serial CRC block: buffers {last,data} words, shifts each
// frame out LSB-first with Active high, then waits for the CRC valid burst.
//   CLK, RST                       : clock, synchronous active-high reset.
//   in_data/in_last/in_valid/in_ready : word input handshake.
//   crc_valid                      : CRC.valid, high while CRC is emitted.
//   Data, Active                   : registered serial stream to CRC block.
//   busy                           : FSM not in IDLE.
//   frame_done/err_underrun/err_timeout : single-cycle status pulses.
module crc_serializer
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = CRC_WIDTH,  // must equal CRC_WIDTH (entry type)
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  crc_valid,
    output logic                  Data,
    output logic                  Active,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_underrun,
    output logic                  err_timeout
);
    localparam int BW = $clog2(DATA_WIDTH);       // DATA_WIDTH >= 2
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  last_q, last_d;
    logic                  seen_hi_q, seen_hi_d;   // crc_valid observed high
    logic                  uflow_q, uflow_d;       // this frame underran
    logic                  active_q, active_d;

    fifo_entry_t           push_entry, head;
    logic                  fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;

    assign push_entry = '{last: in_last, data: in_data};

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (in_valid && !fifo_full),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
    // shreg is cleared whenever SHIFT is left, so bit 0 doubles as Data.
    assign Data     = shreg_q[0];
    assign Active   = active_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            tcnt_q    <= '0;
            last_q    <= 1'b0;
            seen_hi_q <= 1'b0;
            uflow_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            tcnt_q    <= tcnt_d;
            last_q    <= last_d;
            seen_hi_q <= seen_hi_d;
            uflow_q   <= uflow_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        tcnt_d    = tcnt_q;
        last_d    = last_q;
        seen_hi_d = seen_hi_q;
        uflow_d   = uflow_q;
        active_d  = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = head.data;
                    last_d   = head.last;
                    bitcnt_d = '0;
                    uflow_d  = 1'b0;
                    active_d = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                active_d = 1'b1;
                if (bitcnt_q != LAST_BIT) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + 1'b1;
                end else if (!last_q && !fifo_empty) begin
                    // Next word of the same frame follows with no gap.
                    fifo_pop = 1'b1;
                    shreg_d  = head.data;
                    last_d   = head.last;
                    bitcnt_d = '0;
                end else begin
                    uflow_d   = !last_q;
                    active_d  = 1'b0;
                    shreg_d   = '0;
                    tcnt_d    = '0;
                    seen_hi_d = 1'b0;
                    state_d   = WAIT_CRC;
                end
            end
            WAIT_CRC: begin
                tcnt_d = tcnt_q + 1'b1;
                if (crc_valid) seen_hi_d = 1'b1;
                if ((seen_hi_q && !crc_valid) || tcnt_q == TW'(TIMEOUT))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion takes priority over a timeout landing on the same cycle.
    always_comb begin
        busy         = (state_q != IDLE);
        frame_done   = 1'b0;
        err_underrun = 1'b0;
        err_timeout  = 1'b0;
        case (state_q)
            SHIFT:
                err_underrun = (bitcnt_q == LAST_BIT) && !last_q && fifo_empty;
            WAIT_CRC: begin
                if (seen_hi_q && !crc_valid) frame_done  = !uflow_q;
                else if (tcnt_q == TW'(TIMEOUT)) err_timeout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_crc_serializer.sv
module tb_crc_serializer;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int TO = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          crc_valid = 1'b0;
    logic          in_ready, Data, Active, busy, frame_done, err_underrun, err_timeout;

    int checks = 0;
    int failures = 0;

    crc_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .crc_valid(crc_valid),
        .Data(Data), .Active(Active), .busy(busy), .frame_done(frame_done),
        .err_underrun(err_underrun), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    // Observation: bits seen while Active, event counters and their cycle stamps.
    logic cap_mem [0:4095];
    int   cap_n = 0, cyc = 0, end_cnt = 0, fd_cnt = 0, ur_cnt = 0, to_cnt = 0;
    int   fall_cyc = 0, ur_cyc = 0, to_cyc = 0;
    logic prev_act = 1'b0;

    always @(negedge CLK) begin
        cyc      <= cyc + 1;
        prev_act <= Active;
        if (Active && cap_n < 4096) begin
            cap_mem[cap_n] <= Data;
            cap_n          <= cap_n + 1;
        end
        if (prev_act && !Active) begin
            end_cnt  <= end_cnt + 1;
            fall_cyc <= cyc;
        end
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (err_underrun) begin
            ur_cnt <= ur_cnt + 1;
            ur_cyc <= cyc;
        end
        if (err_timeout) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk("push_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input int e0);
        int n = 0;
        while (end_cnt == e0 && n < 400) begin
            tick();
            n++;
        end
        chk("frame_end", 64'(end_cnt - e0), 64'd1);
    endtask

    task automatic crc_pulse(input int dly, input int len);
        repeat (dly) tick();
        crc_valid = 1'b1;
        repeat (len) tick();
        crc_valid = 1'b0;
        repeat (3) tick();
    endtask

    // Reference: a frame is its words concatenated, each sent LSB first,
    // so captured bit i equals bit i of {w[n-1],...,w[0]}.
    function automatic logic [63:0] captured(input int s, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < 64; i++) v[i] = cap_mem[s + i];
        return v;
    endfunction

    initial begin
        int s, e, f, u, t, n, nw;
        logic [DW-1:0] w [5];
        logic [63:0] expv;

        // Reset state
        repeat (3) tick();
        chk("rst_active", 64'(Active), 64'd0);
        chk("rst_data", 64'(Data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pulses", 64'({frame_done, err_underrun, err_timeout}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        RST = 1'b0;
        tick();

        // Single-word frame, start latency
        s = cap_n; e = end_cnt; f = fd_cnt;
        push(8'hA5, 1'b1);
        chk("a5_lat_k", 64'(Active), 64'd0);
        tick();
        chk("a5_lat_k1", 64'({Active, Data}), 64'b11);
        wait_end(e);
        chk("a5_len", 64'(cap_n - s), 64'd8);
        chk("a5_bits", captured(s, 8), 64'hA5);
        crc_pulse(0, 8);
        chk("a5_done", 64'(fd_cnt - f), 64'd1);
        chk("a5_idle", 64'(busy), 64'd0);

        // Back-to-back words in one frame
        s = cap_n; e = end_cnt; f = fd_cnt;
        push(8'h01, 1'b0);
        push(8'h80, 1'b1);
        wait_end(e);
        chk("b2b_len", 64'(cap_n - s), 64'd16);
        chk("b2b_bits", captured(s, 16), 64'h8001);
        crc_pulse(1, 8);
        chk("b2b_done", 64'(fd_cnt - f), 64'd1);

        // Underrun
        s = cap_n; e = end_cnt; f = fd_cnt; u = ur_cnt;
        push(8'h3C, 1'b0);
        wait_end(e);
        chk("ur_len", 64'(cap_n - s), 64'd8);
        chk("ur_bits", captured(s, 8), 64'h3C);
        chk("ur_pulse", 64'(ur_cnt - u), 64'd1);
        chk("ur_at_bit8", 64'(fall_cyc - ur_cyc), 64'd1);
        crc_pulse(0, 8);
        chk("ur_no_done", 64'(fd_cnt - f), 64'd0);
        chk("ur_idle", 64'(busy), 64'd0);

        // Timeout with crc_valid held low
        s = cap_n; e = end_cnt; f = fd_cnt; t = to_cnt;
        w[0] = DW'($urandom);
        push(w[0], 1'b1);
        wait_end(e);
        chk("to_bits", captured(s, 8), 64'(w[0]));
        n = 0;
        while (to_cnt == t && n < 100) begin
            tick();
            n++;
        end
        chk("to_pulse", 64'(to_cnt - t), 64'd1);
        chk("to_cycles", 64'(to_cyc - fall_cyc), 64'(TO));
        tick();
        chk("to_idle", 64'(busy), 64'd0);
        chk("to_no_done", 64'(fd_cnt - f), 64'd0);

        // Backpressure while stalled in WAIT_CRC
        s = cap_n; e = end_cnt; f = fd_cnt;
        push(8'h5A, 1'b1);
        wait_end(e);
        chk("bp0_bits", captured(s, 8), 64'h5A);
        for (int i = 0; i < 5; i++) w[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) push(w[i], 1'b0);
        chk("bp_full", 64'(in_ready), 64'd0);
        in_data = w[4]; in_last = 1'b1; in_valid = 1'b1;
        tick(); tick();
        chk("bp_hold", 64'(in_ready), 64'd0);
        s = cap_n; e = end_cnt;
        crc_valid = 1'b1;
        repeat (8) tick();
        crc_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("bp_ready_again", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp0_done", 64'(fd_cnt - f), 64'd1);
        wait_end(e);
        expv = {24'd0, w[4], w[3], w[2], w[1], w[0]};
        chk("bp_len", 64'(cap_n - s), 64'd40);
        chk("bp_order", captured(s, 40), expv);
        f = fd_cnt;
        crc_pulse(2, 5);
        chk("bp_done", 64'(fd_cnt - f), 64'd1);

        // Reset mid-frame at bit 3
        s = cap_n;
        in_data = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (cap_n - s < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_bit3", 64'({Active, Data}), 64'b11);
        RST = 1'b1;
        tick();
        chk("mid_rst", 64'({Active, Data, busy, in_ready}), 64'b0001);
        RST = 1'b0;
        s = cap_n;
        repeat (4) tick();
        chk("mid_fifo_empty", 64'({Active, busy, 5'(cap_n - s)}), 64'd0);
        s = cap_n; e = end_cnt; f = fd_cnt;
        push(8'h0F, 1'b1);
        wait_end(e);
        chk("post_len", 64'(cap_n - s), 64'd8);
        chk("post_bits", captured(s, 8), 64'h0F);
        crc_pulse(0, 8);
        chk("post_done", 64'(fd_cnt - f), 64'd1);

        // Randomized frames against the concatenation model
        for (int fr = 0; fr < 6; fr++) begin
            nw = $urandom_range(1, 3);
            expv = '0;
            s = cap_n; e = end_cnt; f = fd_cnt; u = ur_cnt;
            for (int i = 0; i < nw; i++) begin
                w[i] = DW'($urandom);
                expv = expv | (64'(w[i]) << (DW * i));
                push(w[i], i == nw - 1);
            end
            wait_end(e);
            chk($sformatf("rnd%0d_len", fr), 64'(cap_n - s), 64'(nw * DW));
            chk($sformatf("rnd%0d_bits", fr), captured(s, nw * DW), expv);
            crc_pulse($urandom_range(0, 3), $urandom_range(1, 8));
            chk($sformatf("rnd%0d_done", fr), 64'({fd_cnt - f, ur_cnt - u}), {32'd1, 32'd0});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
